// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_loader_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    L_IDLE, L_LEN0, L_LEN1, L_DATA, L_WRITE, L_CSUM, L_DONE, L_ERR
  } ld_state_t;

  localparam int          LEN_W         = 16;
  localparam int          IDX_W         = 15;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/uart_loader_rx.sv
// UART receiver: 2-flop synchronizer, baud counter, 8N1 framing with
// mid-bit sampling. Emits one-cycle byte_valid / frame_err pulses.
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int              CNT_W   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync;
  logic             rx_s;
  rx_state_t        st, st_d;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             at_half, at_full;

  assign rx_s    = sync[1];
  assign at_half = (cnt == HALF_M1);
  assign at_full = (cnt == FULL_M1);

  always_comb begin
    st_d = st;
    case (st)
      RX_IDLE:  if (!rx_s) st_d = RX_START;
      // a start bit that is high again at mid-bit was only a glitch
      RX_START: if (at_half) st_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (at_full && bit_idx == 3'd7) st_d = RX_STOP;
      RX_STOP:  if (at_full) st_d = RX_IDLE;
      default:  st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= 2'b11;
      st         <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[0], rx};
      st         <= st_d;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      cnt        <= (st_d != st || at_full) ? '0 : cnt + 1'b1;
      case (st)
        RX_DATA: if (at_full) begin
          shreg   <= {rx_s, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
        RX_STOP: if (at_full) begin
          if (rx_s) begin
            data       <= shreg;
            byte_valid <= 1'b1;
          end else begin
            frame_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Serial program loader: length-prefixed byte stream -> 32-bit memory writes.
// Optional trailing XOR checksum enabled by defining UART_LOADER_CSUM_EN.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 217,
  parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
  parameter int          MAX_WORDS    = 16384,
  parameter int          WE_HOLD      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int HOLD_W = $clog2(WE_HOLD + 1);
`ifdef UART_LOADER_CSUM_EN
  localparam ld_state_t FIN_ST = L_CSUM;
`else
  localparam ld_state_t FIN_ST = L_DONE;
`endif

  logic [7:0]       rx_byte;
  logic             byte_valid, frame_err;
  ld_state_t        ld, ld_d;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] len, len_new;
  logic [IDX_W-1:0] idx, idx_inc;
  logic [1:0]       lane;
  logic [23:0]      wbuf;
  logic [HOLD_W-1:0] hold;
  logic             hold_end, last_word;
`ifdef UART_LOADER_CSUM_EN
  logic [7:0]       csum;
`endif

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  assign len_new   = {rx_byte, len_lo};
  assign idx_inc   = idx + 1'b1;
  assign last_word = ({1'b0, idx_inc} == len);
  assign hold_end  = (hold == HOLD_W'(WE_HOLD - 1));

  always_comb begin
    ld_d   = ld;
    mem_we = 1'b0;
    case (ld)
      L_IDLE: if (start) ld_d = L_LEN0;
      L_LEN0: if (byte_valid) ld_d = L_LEN1;
      L_LEN1: if (byte_valid) begin
        if (len_new == '0)
          ld_d = FIN_ST;
        else if ({1'b0, len_new} > (LEN_W+1)'(MAX_WORDS))
          ld_d = L_ERR;
        else
          ld_d = L_DATA;
      end
      L_DATA: if (byte_valid && lane == 2'd3) ld_d = L_WRITE;
      L_WRITE: begin
        mem_we = 1'b1;
        if (hold_end) ld_d = last_word ? FIN_ST : L_DATA;
      end
`ifdef UART_LOADER_CSUM_EN
      L_CSUM: if (byte_valid) ld_d = (rx_byte == csum) ? L_DONE : L_ERR;
`endif
      L_DONE, L_ERR: ld_d = L_IDLE;
      default: ld_d = L_IDLE;
    endcase
    // a write never overlaps a byte, so L_WRITE cannot see a framing error
    if (frame_err && ld inside {L_LEN0, L_LEN1, L_DATA, L_CSUM})
      ld_d = L_ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld        <= L_IDLE;
      len_lo    <= '0;
      len       <= '0;
      idx       <= '0;
      lane      <= '0;
      wbuf      <= '0;
      hold      <= '0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
      csum      <= '0;
`endif
    end else begin
      ld <= ld_d;
      case (ld)
        L_IDLE: if (start) begin
          done <= 1'b0;
          err  <= 1'b0;
          busy <= 1'b1;
          idx  <= '0;
          lane <= '0;
          hold <= '0;
`ifdef UART_LOADER_CSUM_EN
          csum <= '0;
`endif
        end
        L_LEN0: if (byte_valid) len_lo <= rx_byte;
        L_LEN1: if (byte_valid) len <= len_new;
        L_DATA: if (byte_valid) begin
          wbuf <= {rx_byte, wbuf[23:8]};
          lane <= lane + 2'd1;
`ifdef UART_LOADER_CSUM_EN
          csum <= csum ^ rx_byte;
`endif
          if (lane == 2'd3) begin
            mem_wdata <= {rx_byte, wbuf};
            mem_addr  <= BASE_ADDR + 32'({idx, 2'b00});
          end
        end
        L_WRITE: begin
          if (hold_end) begin
            hold <= '0;
            idx  <= idx_inc;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        default: ;
      endcase
      if (ld_d == L_DONE) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
      if (ld_d == L_ERR) begin
        err  <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Randomized self-checking bench for uart_loader: frames are built from word
// lists, expected writes/status derived directly from the frame rules.
module tb_uart_loader;

  localparam int          CPB  = 8;
  localparam int          HOLD = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, start, rx;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we, busy, done, err;

  always #5 clk = ~clk;

  uart_loader #(
    .CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .MAX_WORDS(16384), .WE_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rx(rx),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy), .done(done), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // write monitor: records each mem_we pulse, its address/data and width
  logic [31:0] got_a[$];
  logic [31:0] got_d[$];
  int          got_w[$];
  int          we_w     = 0;
  logic        we_prev  = 1'b0;
  int          unstable = 0;

  always @(negedge clk) begin
    we_prev <= mem_we;
    if (mem_we && !we_prev) begin
      got_a.push_back(mem_addr);
      got_d.push_back(mem_wdata);
      we_w <= 1;
    end else if (mem_we) begin
      we_w <= we_w + 1;
      if (mem_addr !== got_a[$] || mem_wdata !== got_d[$]) unstable <= unstable + 1;
    end else if (we_prev) begin
      got_w.push_back(we_w);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin rx = b[i]; tick(CPB); end
    rx = stop; tick(CPB);
    rx = 1'b1; tick(3);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  mem_addr,  BASE);
    check({tag, "_wdata"}, mem_wdata, 32'h0);
    check({tag, "_we"},    32'(mem_we), 32'h0);
    check({tag, "_busy"},  32'(busy), 32'h0);
    check({tag, "_done"},  32'(done), 32'h0);
    check({tag, "_err"},   32'(err),  32'h0);
  endtask

  // Reference: N words -> N writes at BASE+4i with the given data, each HOLD
  // cycles wide; status is done unless the checksum byte is corrupted.
  logic [31:0] words[$];

  task automatic run_frame(input bit bad_csum, input bit poke_start, input string tag);
    int          a0 = got_a.size();
    int          w0 = got_w.size();
    int          u0 = unstable;
    int          n  = words.size();
    logic [7:0]  x  = 8'h00;
    logic [7:0]  b;
    bit          exp_err = 1'b0;
    pulse_start(); tick(2);
    send_byte(n[7:0], 1'b1);
    if (poke_start) pulse_start();
    send_byte(n[15:8], 1'b1);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        b = words[i][8*k +: 8];
        x = x ^ b;
        send_byte(b, 1'b1);
      end
`ifdef UART_LOADER_CSUM_EN
    send_byte(bad_csum ? (x ^ 8'h01) : x, 1'b1);
    exp_err = bad_csum;
`endif
    tick(20);
    check({tag, "_nwr"}, 32'(got_a.size() - a0), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (a0 + i < got_a.size()) begin
        check($sformatf("%s_addr%0d", tag, i), got_a[a0+i], BASE + 32'(4*i));
        check($sformatf("%s_data%0d", tag, i), got_d[a0+i], words[i]);
      end
      if (w0 + i < got_w.size())
        check($sformatf("%s_we_w%0d", tag, i), 32'(got_w[w0+i]), 32'(HOLD));
    end
    check({tag, "_stable"}, 32'(unstable - u0), 32'h0);
    check({tag, "_done"}, 32'(done), 32'(!exp_err));
    check({tag, "_err"},  32'(err),  32'(exp_err));
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int a0;
    rst = 1'b1; start = 1'b0; rx = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0; tick(2);

    // directed image from the bring-up flow
    words.delete();
    words.push_back(32'h1234_5678);
    words.push_back(32'hDEAD_BEEF);
    run_frame(1'b0, 1'b0, "dir");

`ifdef UART_LOADER_CSUM_EN
    run_frame(1'b1, 1'b0, "dir_badcsum");
`endif

    // random images; start pokes mid-frame must be ignored
    for (int it = 0; it < 6; it++) begin
      words.delete();
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) words.push_back($urandom);
      run_frame(it == 3, it == 1, $sformatf("rnd%0d", it));
    end

    // empty image
    words.delete();
    run_frame(1'b0, 1'b0, "empty");

    // length over MAX_WORDS: error on the second length byte, no writes
    a0 = got_a.size();
    pulse_start(); tick(2);
    send_byte(8'h01, 1'b1);
    send_byte(8'h40, 1'b1);
    check("len_err", 32'(err), 32'h1);
    check("len_done", 32'(done), 32'h0);
    check("len_busy", 32'(busy), 32'h0);
    for (int k = 0; k < 4; k++) send_byte(8'($urandom), 1'b1);
    tick(10);
    check("len_nwr", 32'(got_a.size() - a0), 32'h0);

    // framing error inside the second word: only the first word lands
    a0 = got_a.size();
    pulse_start(); tick(2);
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b0);
    tick(10);
    check("ferr_err", 32'(err), 32'h1);
    check("ferr_done", 32'(done), 32'h0);
    check("ferr_busy", 32'(busy), 32'h0);
    check("ferr_nwr", 32'(got_a.size() - a0), 32'h1);
    if (got_a.size() > a0) check("ferr_data0", got_d[a0], 32'h4433_2211);

    // 3-cycle glitch while waiting for the length must not produce a byte
    pulse_start(); tick(2);
    rx = 1'b0; tick(3); rx = 1'b1; tick(20);
    words.delete();
    words.push_back(32'hCAFE_F00D);
    run_frame(1'b0, 1'b0, "glitch");

    // reset in the middle of a word aborts everything
    a0 = got_a.size();
    pulse_start(); tick(2);
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
    rx = 1'b0; tick(12);
    rst = 1'b1; tick(1);
    check_reset_outputs("midrst");
    rx = 1'b1; tick(2);
    rst = 1'b0;
    send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
    tick(20);
    check("midrst_nwr", 32'(got_a.size() - a0), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
